// File: rtl/usb_rx_byte_decoder_pkg.sv
// Shared types and constants for the USB receive byte decoder.
// Optional stuff-violation reporting is enabled with macro USB_RX_STUFF_ERR_EN.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RECEIVE    = 3'd1,
    EOP_SE0    = 3'd2,
    EOP_WAIT_J = 3'd3,
    STUFF_ERR  = 3'd4
  } rx_state_e;

  // Line states are encoded as {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam int DEF_STUFF_LIMIT  = 6;
  localparam int DEF_EOP_SE0_BITS = 2;

  // SE1 is not a legal bus state and is folded onto J
  function automatic logic [1:0] line_state(input logic dp, input logic dm);
    logic [1:0] ls;
    case ({dp, dm})
      2'b00:   ls = LINE_SE0;
      2'b01:   ls = LINE_K;
      2'b10:   ls = LINE_J;
      default: ls = LINE_J;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_rx_byte_decoder_if.sv
// Line-side inputs and buffer-side outputs of the USB receive byte decoder.
interface usb_rx_byte_decoder_if;
  logic       d_plus_sync;
  logic       d_minus_sync;
  logic       shift_enable;
  logic       clear;
  logic [7:0] Packet_Data;
  logic       byte_complete;
  logic       eop;
  logic       rx_active;
  logic       stuff_error;

  modport master (
    output d_plus_sync, d_minus_sync, shift_enable, clear,
    input  Packet_Data, byte_complete, eop, rx_active, stuff_error
  );

  modport slave (
    input  d_plus_sync, d_minus_sync, shift_enable, clear,
    output Packet_Data, byte_complete, eop, rx_active, stuff_error
  );
endinterface

// File: rtl/usb_rx_byte_decoder_nrzi_decode.sv
// NRZI decoder: tracks the previous line level and classifies each bit-centre sample.
module usb_rx_nrzi_decode
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  input  logic       shift_enable,
  output logic       sample_valid,
  output logic [1:0] line,
  output logic       bit_out
);
  logic prev_level_q;
  logic prev_level_d;

  assign line         = line_state(d_plus_sync, d_minus_sync);
  assign sample_valid = shift_enable & ~clear;
  assign bit_out      = (d_plus_sync == prev_level_q);

  // Level tracking skips SE0 so the first post-EOP bit decodes against J
  always_comb begin
    prev_level_d = prev_level_q;
    if (clear) begin
      prev_level_d = 1'b1;
    end else if (shift_enable && (line != LINE_SE0)) begin
      prev_level_d = d_plus_sync;
    end else begin
      prev_level_d = prev_level_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_level_q <= 1'b1;
    end else begin
      prev_level_q <= prev_level_d;
    end
  end
endmodule

// File: rtl/usb_rx_byte_decoder.sv
// USB receive byte decoder: NRZI decode, bit unstuffing, LSB-first framing and EOP detection.
// Define USB_RX_STUFF_ERR_EN to report stuff violations and framing errors on stuff_error.
module usb_rx_byte_decoder
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT,
  parameter int EOP_SE0_BITS = DEF_EOP_SE0_BITS
) (
  input logic                  clk,
  input logic                  n_rst,
  usb_rx_byte_decoder_if.slave bus
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int SW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [OW-1:0] ONES_MAX     = OW'(STUFF_LIMIT);
  localparam logic [OW-1:0] ONES_ONE     = OW'(1);
  localparam logic [SW-1:0] SE0_LAST     = SW'(EOP_SE0_BITS - 1);
  localparam logic [SW-1:0] SE0_ONE      = SW'(1);
  localparam logic          EOP_ON_FIRST = (EOP_SE0_BITS <= 1);

  logic       sample_s;
  logic [1:0] line_s;
  logic       bit_s;
  logic       take_bit_s;

  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [SW-1:0] se0_cnt_q, se0_cnt_d;
  logic          byte_complete_q, byte_complete_d;
  logic          eop_q, eop_d;
  logic          rx_active_q, rx_active_d;
  logic          stuff_error_q, stuff_error_d;

  usb_rx_nrzi_decode u_nrzi (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (bus.clear),
    .d_plus_sync  (bus.d_plus_sync),
    .d_minus_sync (bus.d_minus_sync),
    .shift_enable (bus.shift_enable),
    .sample_valid (sample_s),
    .line         (line_s),
    .bit_out      (bit_s)
  );

  // Next-state logic: frame control first, then the shared data-bit path
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    data_d          = data_q;
    bit_cnt_d       = bit_cnt_q;
    ones_d          = ones_q;
    se0_cnt_d       = se0_cnt_q;
    rx_active_d     = rx_active_q;
    byte_complete_d = 1'b0;
    eop_d           = 1'b0;
    stuff_error_d   = 1'b0;
    take_bit_s      = 1'b0;

    if (bus.clear) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      ones_d      = '0;
      se0_cnt_d   = '0;
      rx_active_d = 1'b0;
    end else if (sample_s) begin
      case (state_q)
        IDLE: begin
          if (line_s == LINE_K) begin
            state_d     = RECEIVE;
            rx_active_d = 1'b1;
            take_bit_s  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RECEIVE: begin
          if (line_s == LINE_SE0) begin
            bit_cnt_d = 3'd0;
            se0_cnt_d = SE0_ONE;
            if (EOP_ON_FIRST) begin
              eop_d   = 1'b1;
              state_d = EOP_WAIT_J;
            end else begin
              state_d = EOP_SE0;
            end
          end else if ((ones_q == ONES_MAX) && !bit_s) begin
            ones_d = '0;
          end else if (ones_q == ONES_MAX) begin
`ifdef USB_RX_STUFF_ERR_EN
            stuff_error_d = 1'b1;
            state_d       = STUFF_ERR;
`else
            take_bit_s    = 1'b1;
`endif
          end else begin
            take_bit_s = 1'b1;
          end
        end
        EOP_SE0: begin
          if (line_s != LINE_SE0) begin
`ifdef USB_RX_STUFF_ERR_EN
            stuff_error_d = 1'b1;
            state_d       = STUFF_ERR;
`else
            state_d       = EOP_WAIT_J;
`endif
          end else if (se0_cnt_q >= SE0_LAST) begin
            eop_d   = 1'b1;
            state_d = EOP_WAIT_J;
          end else begin
            se0_cnt_d = se0_cnt_q + SE0_ONE;
          end
        end
        EOP_WAIT_J: begin
          if (line_s == LINE_J) begin
            state_d     = IDLE;
            rx_active_d = 1'b0;
            ones_d      = '0;
            bit_cnt_d   = 3'd0;
          end else begin
            state_d = EOP_WAIT_J;
          end
        end
        STUFF_ERR: begin
          // Data is ignored; only an SE0 can terminate the packet
          if (line_s == LINE_SE0) begin
            bit_cnt_d = 3'd0;
            se0_cnt_d = SE0_ONE;
            if (EOP_ON_FIRST) begin
              eop_d   = 1'b1;
              state_d = EOP_WAIT_J;
            end else begin
              state_d = EOP_SE0;
            end
          end else begin
            state_d = STUFF_ERR;
          end
        end
        default: begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          ones_d      = '0;
          rx_active_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (take_bit_s) begin
      shift_d   = {bit_s, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (!bit_s) begin
        ones_d = '0;
      end else if (ones_q == ONES_MAX) begin
        ones_d = ones_q;
      end else begin
        ones_d = ones_q + ONES_ONE;
      end
      if (bit_cnt_q == 3'd7) begin
        data_d          = {bit_s, shift_q[7:1]};
        byte_complete_d = 1'b1;
      end else begin
        data_d = data_q;
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      shift_q         <= SYNC_BYTE;
      data_q          <= 8'h00;
      bit_cnt_q       <= 3'd0;
      ones_q          <= '0;
      se0_cnt_q       <= '0;
      byte_complete_q <= 1'b0;
      eop_q           <= 1'b0;
      rx_active_q     <= 1'b0;
      stuff_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      bit_cnt_q       <= bit_cnt_d;
      ones_q          <= ones_d;
      se0_cnt_q       <= se0_cnt_d;
      byte_complete_q <= byte_complete_d;
      eop_q           <= eop_d;
      rx_active_q     <= rx_active_d;
      stuff_error_q   <= stuff_error_d;
    end
  end

  assign bus.Packet_Data   = data_q;
  assign bus.byte_complete = byte_complete_q;
  assign bus.eop           = eop_q;
  assign bus.rx_active     = rx_active_q;
  assign bus.stuff_error   = stuff_error_q;
endmodule

// File: tb/tb_usb_rx_byte_decoder.sv
// Scoreboard bench for usb_rx_byte_decoder: directed line patterns, queued expectations.
module tb_usb_rx_byte_decoder;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic tb_prev = 1'b1;
  int   n_total = 0;
  int   n_pass = 0;
  int   exp_eop = 0;
  int   exp_stuff = 0;
  logic [7:0] exp_bytes[$];
  logic [7:0] sync_lvls = 8'b0010_1010;
  logic [7:0] pid_in = 8'h69;

  usb_rx_byte_decoder_if bus();

  usb_rx_byte_decoder dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got a pulse (Packet_Data=%0h), required none", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT pulses an output
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.byte_complete) begin
        if (exp_bytes.size() == 0) unexpected("byte_complete", bus.Packet_Data);
        else check("packet_data", bus.Packet_Data, exp_bytes.pop_front());
      end
      if (bus.eop) begin
        if (exp_eop == 0) unexpected("eop", bus.Packet_Data);
        else begin
          exp_eop--;
          check("eop_rx_active", bus.rx_active, 1);
          check("eop_no_byte", bus.byte_complete, 0);
        end
      end
      if (bus.stuff_error) begin
        if (exp_stuff == 0) unexpected("stuff_error", bus.Packet_Data);
        else begin
          exp_stuff--;
          check("stuff_no_byte", bus.byte_complete, 0);
        end
      end
    end
  end

  task automatic strobe(input logic dp, input logic dm);
    @(negedge clk);
    bus.d_plus_sync = dp; bus.d_minus_sync = dm; bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.shift_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    logic lvl;
    lvl = b ? tb_prev : ~tb_prev;
    tb_prev = lvl;
    strobe(lvl, ~lvl);
  endtask

  task automatic send_j(input int n);
    for (int i = 0; i < n; i++) strobe(1'b1, 1'b0);
    tb_prev = 1'b1;
  endtask

  task automatic send_sync();
    exp_bytes.push_back(8'h80);
    for (int i = 0; i < 8; i++) strobe(sync_lvls[i], ~sync_lvls[i]);
    tb_prev = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_eop();
    exp_eop++;
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b0);
    send_j(1);
  endtask

  initial begin
    bus.d_plus_sync = 1'b1; bus.d_minus_sync = 1'b0;
    bus.shift_enable = 1'b0; bus.clear = 1'b0;
    #3 n_rst = 1'b0;
    #1;
    check("rst_packet_data", bus.Packet_Data, 8'h00);
    check("rst_byte_complete", bus.byte_complete, 0);
    check("rst_eop", bus.eop, 0);
    check("rst_rx_active", bus.rx_active, 0);
    check("rst_stuff_error", bus.stuff_error, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Packet 1: sync, IN PID, 0xFF with a stuffed zero, EOP
    send_j(3);
    check("idle_rx_active", bus.rx_active, 0);
    send_sync();
    check("sync_rx_active", bus.rx_active, 1);
    exp_bytes.push_back(8'h69);
    send_byte(pid_in);
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
    check("ff_pending", exp_bytes.size(), 1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("ff_done", exp_bytes.size(), 0);
    send_eop();
    check("eop1_rx_active", bus.rx_active, 0);

    // Packet 2: partial byte discarded by EOP
    send_sync();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_eop();
    check("eop2_rx_active", bus.rx_active, 0);

    // Packet 3: seven consecutive ones without stuffing
    send_sync();
    exp_bytes.push_back(8'h69);
    send_byte(pid_in);
`ifdef USB_RX_STUFF_ERR_EN
    exp_stuff++;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("stuff_seen", exp_stuff, 0);
    send_bit(1'b1); send_bit(1'b0);
    send_eop();
`else
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    check("seven_ones_byte", exp_bytes.size(), 0);
    check("stuff_error_low", bus.stuff_error, 0);
    send_eop();
`endif
    check("eop3_rx_active", bus.rx_active, 0);

    // Packet 4: reset in the middle of a byte
    send_sync();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("pre_rst_data", bus.Packet_Data, 8'h80);
    n_rst = 1'b0;
    #1;
    check("mid_rst_packet_data", bus.Packet_Data, 8'h00);
    check("mid_rst_rx_active", bus.rx_active, 0);
    @(negedge clk);
    n_rst = 1'b1;
    send_j(2);
    send_sync();
    send_eop();

    // Packet 5: clear coinciding with a strobe
    send_sync();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    bus.d_plus_sync = 1'b0; bus.d_minus_sync = 1'b1;
    bus.shift_enable = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.shift_enable = 1'b0; bus.clear = 1'b0;
    check("clear_rx_active", bus.rx_active, 0);
    check("clear_hold_data", bus.Packet_Data, 8'h80);
    send_j(2);
    send_sync();
    send_eop();

    repeat (4) @(negedge clk);
    check("bytes_left", exp_bytes.size(), 0);
    check("eops_left", exp_eop, 0);
    check("stuff_left", exp_stuff, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
